insn_encoder: RTL

INSN_ENCODER -- requirements
Module: insn_encoder

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/insn_pack.sv | 52 +++++
 rtl/insn_encoder.sv | 56 +++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode-class codes (opcode[6:2]) and instruction format selection
package riscv_pkg;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;
  function automatic fmt_e fmt_of(input logic [4:0] c);
    return (c == OPC_LUI || c == OPC_AUIPC) ? FMT_U :
           (c == OPC_JAL) ? FMT_J :
           (c == OPC_BRANCH) ? FMT_B :
           (c == OPC_JALR || c == OPC_OPIMM || c == OPC_LOAD) ? FMT_I :
           (c == OPC_STORE) ? FMT_S :
           (c == OPC_OP) ? FMT_R : FMT_BAD;
  endfunction
endpackage

// File: rtl/insn_pack.sv
// insn_pack: combinational RV32I field packing and immediate legality check
module insn_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] insn,
  output logic        err
);
  fmt_e fmt;
  logic shift, ext11, ext12, ext20;
  always_comb begin
    fmt   = (opcode[1:0] == 2'b11) ? fmt_of(opcode[6:2]) : FMT_BAD;
    shift = (opcode[6:2] == OPC_OPIMM) && (funct3[1:0] == 2'b01);
    // immediate fits when all bits above the field's sign bit match it
    ext11 = (&imm[31:11]) | ~(|imm[31:11]);
    ext12 = (&imm[31:12]) | ~(|imm[31:12]);
    ext20 = (&imm[31:20]) | ~(|imm[31:20]);
    insn  = '0;
    err   = 1'b0;
    case (fmt)
      FMT_R: insn = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        insn = shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode} : {imm[11:0], rs1, funct3, rd, opcode};
        err  = shift ? |imm[31:5] : !ext11;
      end
      FMT_S: begin
        insn = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !ext11;
      end
      FMT_B: begin
        insn = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !ext12 | imm[0];
      end
      FMT_U: begin
        insn = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      FMT_J: begin
        insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !ext20 | imm[0];
      end
      default: err = 1'b1;
    endcase
    if (err) insn = '0;
  end
endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: valid/ready RV32I encoder with output register, 1-entry skid buffer and error counter
module insn_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] insn,
  output logic        err,
  output logic [7:0]  err_count
);
  logic [31:0] p_insn, skid_insn;
  logic        p_err, skid_err, skid_valid, accept, out_free;
  insn_pack u_pack (
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .insn(p_insn), .err(p_err)
  );
  assign accept   = in_valid & in_ready;
  assign out_free = !out_valid | out_ready;
  // in_ready mirrors an empty skid, so a filled skid never sees a second write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      insn       <= '0;
      err        <= 1'b0;
      skid_valid <= 1'b0;
      skid_insn  <= '0;
      skid_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      if (out_free) begin
        out_valid  <= skid_valid | accept;
        insn       <= skid_valid ? skid_insn : accept ? p_insn : insn;
        err        <= skid_valid ? skid_err : accept ? p_err : err;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (accept) begin
        skid_insn  <= p_insn;
        skid_err   <= p_err;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end
      if (out_valid && out_ready && err && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
endmodule
